// File: rtl/la_xortree_if.sv
// la_xortree_if: beat input and parity result handshake bundle for la_xortree
interface la_xortree_if #(
  parameter int N  = 32,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          accum;
  logic          out_valid;
  logic          out_ready;
  logic          out_parity;
  logic [CW-1:0] out_beats;
  modport master (
    output in_valid, in_data, in_last, accum, out_ready,
    input  in_ready, out_valid, out_parity, out_beats
  );
  modport slave (
    input  in_valid, in_data, in_last, accum, out_ready,
    output in_ready, out_valid, out_parity, out_beats
  );
endinterface

// File: rtl/la_xortree.sv
// la_xortree: pipelined RADIX-ary XOR reduction tree with per-beat packet accumulation
module la_xortree #(
  parameter int    N     = 32,
  parameter int    RADIX = 3,
  parameter int    ODD   = 0,
  parameter int    CW    = 8,
  parameter string PROP  = "DEFAULT"
) (
  input logic clk,
  input logic nreset,
  la_xortree_if.slave io
);
  function automatic int levels();
    int w = N;
    int l = 0;
    while (w > 1) begin
      w = (w + RADIX - 1) / RADIX;
      l++;
    end
    return l;
  endfunction
  // one tree level: bit i joins node i/RADIX; unused upper bits stay zero, padding partial groups
  function automatic logic [N-1:0] fold(input logic [N-1:0] v);
    fold = '0;
    for (int i = 0; i < N; i++) fold[i/RADIX] = fold[i/RADIX] ^ v[i];
  endfunction
  localparam int   L   = levels();
  localparam logic INV = (ODD != 0);
  logic [N-1:0]  vec [L];
  logic [N-1:0]  nxt [L];
  logic [L-1:0]  sv, sa, sl;
  logic          acc, p, adv;
  logic [CW-1:0] cnt, cnt_inc;
  always_comb
    for (int k = 0; k < L; k++) nxt[k] = fold(vec[k]);
  assign p           = ^nxt[L-1];
  assign adv         = !io.out_valid | io.out_ready;
  assign io.in_ready = adv;
  assign cnt_inc     = &cnt ? cnt : cnt + 1'b1;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      for (int k = 0; k < L; k++) vec[k] <= '0;
      sv            <= '0;
      sa            <= '0;
      sl            <= '0;
      acc           <= 1'b0;
      cnt           <= '0;
      io.out_valid  <= 1'b0;
      io.out_parity <= 1'b0;
      io.out_beats  <= '0;
    end else if (adv) begin
      vec[0] <= io.in_data;
      sv[0]  <= io.in_valid;
      sa[0]  <= io.accum;
      sl[0]  <= io.in_last;
      for (int k = 1; k < L; k++) begin
        vec[k] <= nxt[k-1];
        sv[k]  <= sv[k-1];
        sa[k]  <= sa[k-1];
        sl[k]  <= sl[k-1];
      end
      // absorbed accumulate beats produce a bubble at the output
      io.out_valid <= sv[L-1] & !(sa[L-1] & !sl[L-1]);
      if (sv[L-1] && !sa[L-1]) begin
        io.out_parity <= p ^ INV;
        io.out_beats  <= CW'(1);
      end else if (sv[L-1] && !sl[L-1]) begin
        acc <= acc ^ p;
        cnt <= cnt_inc;
      end else if (sv[L-1]) begin
        io.out_parity <= acc ^ p ^ INV;
        io.out_beats  <= cnt_inc;
        acc           <= 1'b0;
        cnt           <= '0;
      end
    end
endmodule

// File: tb/tb_la_xortree.sv
// tb_la_xortree: table, directed and random checks of three la_xortree builds sharing one stimulus
module tb_la_xortree;
  logic        clk = 1'b0, nreset = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, accum = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  always #5 clk = ~clk;
  la_xortree_if #(.N(32), .CW(8)) ia ();
  la_xortree_if #(.N(32), .CW(8)) ib ();
  la_xortree_if #(.N(32), .CW(2)) ic ();
  assign ia.in_valid = in_valid; assign ia.in_data = in_data; assign ia.in_last = in_last; assign ia.accum = accum; assign ia.out_ready = out_ready;
  assign ib.in_valid = in_valid; assign ib.in_data = in_data; assign ib.in_last = in_last; assign ib.accum = accum; assign ib.out_ready = out_ready;
  assign ic.in_valid = in_valid; assign ic.in_data = in_data; assign ic.in_last = in_last; assign ic.accum = accum; assign ic.out_ready = out_ready;
  la_xortree #(.N(32), .RADIX(3), .ODD(0), .CW(8)) dut_a (.clk(clk), .nreset(nreset), .io(ia));
  la_xortree #(.N(32), .RADIX(3), .ODD(1), .CW(8)) dut_b (.clk(clk), .nreset(nreset), .io(ib));
  la_xortree #(.N(32), .RADIX(3), .ODD(0), .CW(2)) dut_c (.clk(clk), .nreset(nreset), .io(ic));
  typedef struct { logic par; int beats; } res_t;
  typedef struct { logic pa; logic pb; int ba; } got_t;
  typedef struct { logic [31:0] d; logic a; logic l; logic e; logic p; int b; } vec_t;
  res_t qa[$], qb[$], qc[$];
  got_t got[$];
  vec_t tbl[$];
  int   tests = 0, fails = 0, cyc = 0, n_out = 0, pk_n = 0;
  int   last_beats_a = 0, last_beats_c = 0;
  logic pk_par = 1'b0, last_par_a = 1'b0;
  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got_v, exp_v, $time);
    end
  endtask
  always @(posedge clk) cyc++;
  // reference: parity of a word is its popcount modulo 2; packets fold popcounts
  always @(negedge clk) begin : monitor
    logic p;
    res_t r;
    if (nreset) begin
      if (in_valid && ia.in_ready) begin
        p = 1'($countones(in_data) % 2);
        if (!accum) begin
          qa.push_back('{p, 1}); qb.push_back('{!p, 1}); qc.push_back('{p, 1});
        end else begin
          pk_par = pk_par ^ p;
          pk_n++;
          if (in_last) begin
            qa.push_back('{pk_par, pk_n > 255 ? 255 : pk_n});
            qb.push_back('{!pk_par, pk_n > 255 ? 255 : pk_n});
            qc.push_back('{pk_par, pk_n > 3 ? 3 : pk_n});
            pk_par = 1'b0;
            pk_n = 0;
          end
        end
      end
      if (ia.out_valid && out_ready) begin
        n_out++;
        got.push_back('{ia.out_parity, ib.out_parity, int'(ia.out_beats)});
        last_par_a = ia.out_parity;
        last_beats_a = int'(ia.out_beats);
        chk("a_pending", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          r = qa.pop_front();
          chk("a_par", 32'(ia.out_parity), 32'(r.par));
          chk("a_beats", 32'(ia.out_beats), r.beats);
        end
      end
      if (ib.out_valid && out_ready) begin
        chk("b_pending", 32'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          r = qb.pop_front();
          chk("b_par", 32'(ib.out_parity), 32'(r.par));
          chk("b_beats", 32'(ib.out_beats), r.beats);
        end
      end
      if (ic.out_valid && out_ready) begin
        last_beats_c = int'(ic.out_beats);
        chk("c_pending", 32'(qc.size() > 0), 1);
        if (qc.size() > 0) begin
          r = qc.pop_front();
          chk("c_par", 32'(ic.out_parity), 32'(r.par));
          chk("c_beats", 32'(ic.out_beats), r.beats);
        end
      end
    end
  end
  task automatic flush_model();
    qa.delete(); qb.delete(); qc.delete();
    pk_par = 1'b0;
    pk_n = 0;
  endtask
  task automatic send(input logic [31:0] d, input logic a, input logic l);
    bit hit;
    int n = 0;
    in_valid = 1'b1; in_data = d; accum = a; in_last = l;
    do begin
      @(negedge clk);
      hit = ia.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hit && n < 50);
    if (!hit) chk("send_timeout", 32'(hit), 1);
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int n, c0, n0, k, emits;
    logic held;
    tbl.push_back('{32'h0000_0007, 1'b0, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b0, 3});
    tbl.push_back('{32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{32'h0000_000F, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{32'h0000_0007, 1'b0, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 2});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ia.out_valid), 0);
    chk("rst_parity", 32'(ia.out_parity), 0);
    chk("rst_beats", 32'(ia.out_beats), 0);
    chk("rst_ready", 32'(ia.in_ready), 1);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    // latency: accept edge to out_valid edge
    send(32'h0000_0007, 1'b0, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!ia.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 4);
    chk("lat_par_a", 32'(ia.out_parity), 1);
    chk("lat_beats_a", 32'(ia.out_beats), 1);
    chk("lat_par_b", 32'(ib.out_parity), 0);
    idle(6);
    got.delete();
    foreach (tbl[i]) send(tbl[i].d, tbl[i].a, tbl[i].l);
    idle(8);
    k = 0;
    emits = 0;
    foreach (tbl[i]) if (tbl[i].e) begin
      emits++;
      if (k < got.size()) begin
        chk($sformatf("tbl%0d_par", i), 32'(got[k].pa), 32'(tbl[i].p));
        chk($sformatf("tbl%0d_par_odd", i), 32'(got[k].pb), 32'(!tbl[i].p));
        chk($sformatf("tbl%0d_beats", i), got[k].ba, tbl[i].b);
      end
      k++;
    end
    chk("tbl_count", got.size(), emits);
    // back-to-back throughput
    c0 = cyc;
    n0 = n_out;
    for (int i = 0; i < 100; i++) send($urandom, 1'b0, 1'b0);
    chk("tput_cycles", cyc - c0, 100);
    idle(8);
    chk("tput_results", n_out - n0, 100);
    // stall with full pipeline and a pending beat
    for (int i = 0; i < 6; i++) send($urandom, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = $urandom;
    accum = 1'b0;
    held = ia.out_parity;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_ready", 32'(ia.in_ready), 0);
      chk("stall_valid", 32'(ia.out_valid), 1);
      chk("stall_hold", 32'(ia.out_parity), 32'(held));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    idle(8);
    chk("stall_drain", qa.size(), 0);
    // saturating beat count with an independent beat mid-packet
    for (int i = 0; i < 3; i++) send(32'h1, 1'b1, 1'b0);
    send(32'h7, 1'b0, 1'b0);
    send(32'h1, 1'b1, 1'b0);
    send(32'h1, 1'b1, 1'b0);
    send(32'h1, 1'b1, 1'b1);
    idle(8);
    chk("sat_beats_c", last_beats_c, 3);
    chk("sat_beats_a", last_beats_a, 6);
    chk("sat_par", 32'(last_par_a), 0);
    // async reset mid-packet while a result is held
    out_ready = 1'b0;
    send(32'h1, 1'b1, 1'b0);
    send(32'h1, 1'b1, 1'b0);
    send(32'h7, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(ia.out_valid), 1);
    chk("pre_rst_par", 32'(ia.out_parity), 1);
    nreset = 1'b0;
    #1;
    flush_model();
    chk("mid_rst_valid", 32'(ia.out_valid), 0);
    chk("mid_rst_par", 32'(ia.out_parity), 0);
    chk("mid_rst_beats", 32'(ia.out_beats), 0);
    chk("mid_rst_ready", 32'(ia.in_ready), 1);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    out_ready = 1'b1;
    send(32'h1, 1'b1, 1'b1);
    idle(8);
    chk("post_rst_beats", last_beats_a, 1);
    chk("post_rst_par", 32'(last_par_a), 1);
    // random mixed traffic with bubbles and backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      accum     = $urandom_range(0, 1) == 1;
      in_last   = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(12);
    chk("final_qa", qa.size(), 0);
    chk("final_qb", qb.size(), 0);
    chk("final_qc", qc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/la_xortree.md
# la_xortree

Parametrised, pipelined XOR-reduction (parity) engine built from RADIX-input XOR nodes, generalising the fixed 3-input XOR cell to any data width. It reduces an N-bit word to one parity bit through registered tree levels with valid/ready flow control. An optional per-beat accumulate mode folds multi-beat packets into a single parity result. It sits in datapaths needing parity generation or checking of buses and packets.

## Interface
Parameters:
- N, 32, input data width (N >= 2)
- RADIX, 3, fan-in of each XOR node (2..4)
- ODD, 0, 1 = output inverted (odd parity), 0 = even parity
- CW, 8, width of beat counter
- PROP, "DEFAULT", implementation property string passed through unchanged

Ports:
- clk  input  1  clock; all state on rising edge
- nreset  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  N  data word to reduce
- in_last  input  1  last beat of packet (used only when beat's accum=1)
- accum  input  1  sampled per beat; 1 = accumulate beat into packet parity
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_parity  output  1  parity result (XOR of all bits, ^ODD)
- out_beats  output  CW  beats folded into this result (1 in non-accum mode)

## Operation
- Levels L = ceil(log_RADIX(N)); level k XORs groups of RADIX bits from level k-1, last group of a level may be partial (pad with 0). Every level is registered.
- Examples: N=32,RADIX=3 -> L=4; N=8,RADIX=2 -> L=3; N=3,RADIX=3 -> L=1.
- Each stage carries {valid, accum, last, partial vector}; accum/last captured with the beat, so changing accum mid-stream affects only later beats.
- Global advance: adv = !out_valid | out_ready. in_ready = adv. All stages load only when adv; otherwise hold.
- Final stage (level L output register) with beat parity p:
  - accum=0: out_parity <= p ^ ODD, out_beats <= 1, out_valid <= 1.
  - accum=1, last=0: acc <= acc ^ p, cnt <= sat(cnt+1); no out_valid (beat absorbed).
  - accum=1, last=1: out_parity <= acc ^ p ^ ODD, out_beats <= sat(cnt+1); acc <= 0, cnt <= 0; out_valid <= 1.
  - No valid beat arriving while adv: out_valid <= 0.
- cnt saturates at 2^CW-1; parity still correct past saturation.
- Accum=0 beat arriving while an accum packet is open: emitted independently; acc/cnt untouched.
- Reset (async assert, any time, including mid-packet): all stage valids 0, acc 0, cnt 0, out_valid 0, out_parity 0, out_beats 0; in_ready = 1 after reset. Partial packet discarded.

## Timing
- Latency: beat accepted at edge t -> out_valid at edge t+L (no stall).
- Throughput: one beat per cycle while out_ready=1.
- out_parity/out_beats stable while out_valid & !out_ready.
- in_ready is combinational from out_valid and out_ready only (no path from in_valid).
- Bubbles held in place during stall (global stall; no compaction).

## Test plan
- N=32,RADIX=3,ODD=0: in_data=32'h0000_0007 accum=0 -> out_parity=1, out_beats=1 exactly 4 cycles after acceptance; 32'hFFFF_FFFF -> 0.
- Back-to-back 100 random words, out_ready=1 -> one result per cycle, each equals ^in_data; ODD=1 build -> all inverted.
- Backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, out_parity held; release -> no loss/duplication, order preserved.
- Accumulate: beats 32'h1, 32'h3, 32'h1(last) accum=1 -> single result out_parity=0, out_beats=3; no out_valid for first two beats.
- CW=2 packet of 6 beats each 32'h1 -> out_beats=3 (saturated), out_parity=0; interleaved accum=0 beat mid-packet -> emitted alone, packet result unaffected.
- Assert nreset mid-packet and with out_valid=1 -> out_valid=0, out_parity=0, out_beats=0 immediately; next packet result excludes pre-reset beats.
